fb_pixel_writer: RTL and testbench

- Write-side client of the 64x48, 4-bit-per-pixel framebuffer; the display fetch path reads the same memory.
- Accepts drawing commands over a valid/ready interface: single-pixel plot, horizontal span, or whole-bank fill.
- Expands each command into per-pixel memory writes using the display path's addressing: addr = {y, x[5:3]}, pix_sel = x[2:0], one bank bit.
- Each write is handed to the memory arbiter over a req/ack handshake.

---
 rtl/fb_pixel_writer_if.sv | 29 ++
 rtl/fb_pixel_writer.sv | 111 +++++++++++
 tb/tb_fb_pixel_writer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pixel_writer_if.sv
// Command and memory-write bundle for the framebuffer pixel writer.
// The writer takes the master modport: it accepts commands and drives memory writes.
interface fb_pixel_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_bank;
  logic [5:0] cmd_x0;
  logic [5:0] cmd_x1;
  logic [5:0] cmd_y;
  logic [3:0] cmd_colour;

  logic       mem_req;
  logic       mem_ack;
  logic       bank;
  logic [8:0] addr;
  logic [2:0] pix_sel;
  logic [3:0] pixel_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_bank, cmd_x0, cmd_x1, cmd_y, cmd_colour, mem_ack,
    output cmd_ready, mem_req, bank, addr, pix_sel, pixel_out
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_bank, cmd_x0, cmd_x1, cmd_y, cmd_colour, mem_ack,
    input  cmd_ready, mem_req, bank, addr, pix_sel, pixel_out
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// Expands plot / span / fill commands into per-pixel writes of the 64x48 4bpp
// framebuffer, one write per mem_req/mem_ack handshake.
module fb_pixel_writer #(
  parameter int H_PIX      = 64,
  parameter int V_PIX      = 48,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic                   clk_25,
  input  logic                   rst_n,
  fb_pixel_writer_if.master      bus,
  input  logic                   disp_active,
  output logic                   busy,
  output logic                   err_oob
);

  typedef enum logic [1:0] {IDLE, WRITE, ERR} state_t;

  localparam logic [1:0] OP_PLOT  = 2'b00;
  localparam logic [1:0] OP_HLINE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [5:0] X_LAST   = 6'(H_PIX - 1);
  localparam logic [5:0] Y_LAST   = 6'(V_PIX - 1);

  state_t     state_q, state_d;
  logic       fill_q;
  logic       bank_q;
  logic [3:0] colour_q;
  logic [5:0] x_q;
  logic [5:0] y_q;
  logic [5:0] x_end_q;

  logic accept;
  logic cmd_bad;
  logic fire;
  logic last_px;

  always_comb begin
    accept  = (state_q == IDLE) && bus.cmd_valid;
    cmd_bad = (bus.cmd_op == OP_RSVD) ||
              ((bus.cmd_op != OP_FILL) && (bus.cmd_y > Y_LAST));
    fire    = bus.mem_req && bus.mem_ack;
    last_px = fill_q ? ((x_q == X_LAST) && (y_q == Y_LAST)) : (x_q == x_end_q);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = cmd_bad ? ERR : WRITE;
      WRITE:   if (fire && last_px) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel cursor: loaded on acceptance, advanced only on an acknowledged write.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      fill_q   <= 1'b0;
      bank_q   <= 1'b0;
      colour_q <= 4'h0;
      x_q      <= 6'd0;
      y_q      <= 6'd0;
      x_end_q  <= 6'd0;
    end else if (accept && !cmd_bad) begin
      bank_q   <= bus.cmd_bank;
      colour_q <= bus.cmd_colour;
      fill_q   <= (bus.cmd_op == OP_FILL);
      if (bus.cmd_op == OP_FILL) begin
        x_q     <= 6'd0;
        y_q     <= 6'd0;
        x_end_q <= X_LAST;
      end else if ((bus.cmd_op == OP_HLINE) && (bus.cmd_x0 > bus.cmd_x1)) begin
        x_q     <= bus.cmd_x1;
        y_q     <= bus.cmd_y;
        x_end_q <= bus.cmd_x0;
      end else begin
        x_q     <= bus.cmd_x0;
        y_q     <= bus.cmd_y;
        x_end_q <= (bus.cmd_op == OP_PLOT) ? bus.cmd_x0 : bus.cmd_x1;
      end
    end else if (state_q == WRITE && fire && !last_px) begin
      if (fill_q && (x_q == X_LAST)) begin
        x_q <= 6'd0;
        y_q <= y_q + 6'd1;
      end else begin
        x_q <= x_q + 6'd1;
      end
    end
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    busy          = (state_q != IDLE);
    err_oob       = (state_q == ERR);
    bus.mem_req   = (state_q == WRITE) && !(BLANK_ONLY && disp_active);
    bus.bank      = bank_q;
    bus.addr      = {y_q, x_q[5:3]};
    bus.pix_sel   = x_q[2:0];
    bus.pixel_out = colour_q;
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: one unrestricted instance and one
// BLANK_ONLY instance, with write/request/error counters sampled on posedge.
module tb_fb_pixel_writer;
  logic clk_25      = 1'b0;
  logic rst_n       = 1'b0;
  logic disp_active = 1'b0;
  logic busy_a, err_a, busy_b, err_b;

  int n_vec = 0;
  int n_bad = 0;

  int wr_a = 0, req_a = 0, errc_a = 0, wr_b = 0;

  fb_pixel_writer_if ia ();
  fb_pixel_writer_if ib ();

  fb_pixel_writer #(.H_PIX(64), .V_PIX(48), .BLANK_ONLY(1'b0)) dut_a (
    .clk_25(clk_25), .rst_n(rst_n), .bus(ia),
    .disp_active(disp_active), .busy(busy_a), .err_oob(err_a)
  );

  fb_pixel_writer #(.H_PIX(64), .V_PIX(48), .BLANK_ONLY(1'b1)) dut_b (
    .clk_25(clk_25), .rst_n(rst_n), .bus(ib),
    .disp_active(disp_active), .busy(busy_b), .err_oob(err_b)
  );

  always #5 clk_25 = ~clk_25;

  always @(posedge clk_25) begin
    if (ia.mem_req && ia.mem_ack) wr_a <= wr_a + 1;
    if (ia.mem_req) req_a <= req_a + 1;
    if (err_a) errc_a <= errc_a + 1;
    if (ib.mem_req && ib.mem_ack) wr_b <= wr_b + 1;
  end

  // Presents a command, holds it across one edge, then scrambles the fields.
  task automatic issue(input bit to_b, input logic [1:0] op, input logic bnk,
                       input logic [5:0] x0, input logic [5:0] x1,
                       input logic [5:0] y, input logic [3:0] col);
    @(negedge clk_25);
    if (!to_b) begin
      ia.cmd_op = op; ia.cmd_bank = bnk; ia.cmd_x0 = x0; ia.cmd_x1 = x1;
      ia.cmd_y = y; ia.cmd_colour = col; ia.cmd_valid = 1'b1;
    end else begin
      ib.cmd_op = op; ib.cmd_bank = bnk; ib.cmd_x0 = x0; ib.cmd_x1 = x1;
      ib.cmd_y = y; ib.cmd_colour = col; ib.cmd_valid = 1'b1;
    end
    @(posedge clk_25);
    #1;
    ia.cmd_valid = 1'b0; ib.cmd_valid = 1'b0;
    ia.cmd_x0 = ~x0; ia.cmd_x1 = ~x1; ia.cmd_y = ~y; ia.cmd_colour = ~col; ia.cmd_bank = ~bnk;
    ib.cmd_x0 = ~x0; ib.cmd_x1 = ~x1; ib.cmd_y = ~y; ib.cmd_colour = ~col; ib.cmd_bank = ~bnk;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_25);
    n_vec++;
    if (ia.mem_req !== 1'b0 || busy_a !== 1'b0 || err_a !== 1'b0) begin
      n_bad++; $display("FAIL rst_ctrl got req=%0b busy=%0b err=%0b want 0 0 0", ia.mem_req, busy_a, err_a);
    end
    n_vec++;
    if (ia.addr !== 9'd0 || ia.pix_sel !== 3'd0 || ia.pixel_out !== 4'd0 || ia.bank !== 1'b0) begin
      n_bad++; $display("FAIL rst_data got addr=%0h pix=%0d data=%0h bank=%0b want 0 0 0 0",
                        ia.addr, ia.pix_sel, ia.pixel_out, ia.bank);
    end
    rst_n = 1'b1;
    @(negedge clk_25);
    n_vec++;
    if (ia.cmd_ready !== 1'b1 || ib.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready got a=%0b b=%0b want 1 1", ia.cmd_ready, ib.cmd_ready);
    end
  endtask

  task automatic test_plot();
    int w0;
    ia.mem_ack = 1'b1;
    w0 = wr_a;
    issue(1'b0, 2'b00, 1'b1, 6'd5, 6'd0, 6'd10, 4'hA);
    @(negedge clk_25);
    n_vec++;
    if (ia.mem_req !== 1'b1 || ia.addr !== 9'h050 || ia.pix_sel !== 3'd5 ||
        ia.pixel_out !== 4'hA || ia.bank !== 1'b1) begin
      n_bad++; $display("FAIL plot_write got req=%0b addr=%0h pix=%0d data=%0h bank=%0b want 1 050 5 a 1",
                        ia.mem_req, ia.addr, ia.pix_sel, ia.pixel_out, ia.bank);
    end
    n_vec++;
    if (ia.cmd_ready !== 1'b0 || busy_a !== 1'b1) begin
      n_bad++; $display("FAIL plot_busy got ready=%0b busy=%0b want 0 1", ia.cmd_ready, busy_a);
    end
    @(negedge clk_25);
    n_vec++;
    if (ia.cmd_ready !== 1'b1 || ia.mem_req !== 1'b0 || (wr_a - w0) !== 1) begin
      n_bad++; $display("FAIL plot_done got ready=%0b req=%0b writes=%0d want 1 0 1",
                        ia.cmd_ready, ia.mem_req, wr_a - w0);
    end
  endtask

  task automatic test_hline();
    int k, e0, w0;
    bit ok;
    logic [8:0] la;
    logic [2:0] lp;
    k = 0; ok = 1'b1; e0 = errc_a; w0 = wr_a; la = '0; lp = '0;
    issue(1'b0, 2'b01, 1'b0, 6'd60, 6'd3, 6'd47, 4'h3);
    @(negedge clk_25);
    n_vec++;
    if (ia.addr !== 9'h178 || ia.pix_sel !== 3'd3) begin
      n_bad++; $display("FAIL hline_first got addr=%0h pix=%0d want 178 3", ia.addr, ia.pix_sel);
    end
    for (int c = 0; c < 200; c++) begin
      logic [5:0] ex;
      if (c != 0) @(negedge clk_25);
      if (!busy_a) break;
      if (ia.mem_req) begin
        ex = 6'(3 + k);
        if (ia.addr !== {6'd47, ex[5:3]} || ia.pix_sel !== ex[2:0] || ia.pixel_out !== 4'h3) ok = 1'b0;
        la = ia.addr; lp = ia.pix_sel; k++;
      end
    end
    n_vec++;
    if (k !== 58 || (wr_a - w0) !== 58) begin
      n_bad++; $display("FAIL hline_count got req_cycles=%0d writes=%0d want 58", k, wr_a - w0);
    end
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL hline_order got out-of-order pixel want x ascending 3..60"); end
    n_vec++;
    if (la !== 9'h17F || lp !== 3'd4) begin
      n_bad++; $display("FAIL hline_last got addr=%0h pix=%0d want 17f 4", la, lp);
    end
    n_vec++;
    if ((errc_a - e0) !== 0) begin n_bad++; $display("FAIL hline_err got %0d pulses want 0", errc_a - e0); end
  endtask

  task automatic test_fill();
    int k, w0;
    bit ok;
    logic [8:0] la;
    logic [2:0] lp;
    k = 0; ok = 1'b1; w0 = wr_a; la = '0; lp = '0;
    issue(1'b0, 2'b10, 1'b0, 6'd9, 6'd20, 6'd33, 4'hF);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_25);
      if (!busy_a) break;
      if (ia.mem_req) begin
        if (ia.addr !== 9'(k >> 3) || ia.pix_sel !== 3'(k & 7) ||
            ia.pixel_out !== 4'hF || ia.bank !== 1'b0) ok = 1'b0;
        la = ia.addr; lp = ia.pix_sel; k++;
      end else begin
        ok = 1'b0;
      end
    end
    n_vec++;
    if (k !== 3072 || (wr_a - w0) !== 3072) begin
      n_bad++; $display("FAIL fill_count got req_cycles=%0d writes=%0d want 3072", k, wr_a - w0);
    end
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL fill_raster got non-raster or gapped write want raster order"); end
    n_vec++;
    if (la !== 9'd383 || lp !== 3'd7 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL fill_last got addr=%0d pix=%0d busy=%0b want 383 7 0", la, lp, busy_a);
    end
  endtask

  task automatic test_stall();
    int w0;
    bit ok;
    w0 = wr_a; ok = 1'b1;
    ia.mem_ack = 1'b0;
    issue(1'b0, 2'b00, 1'b1, 6'd17, 6'd0, 6'd3, 4'h6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_25);
      if (ia.mem_req !== 1'b1 || ia.addr !== 9'h01A || ia.pix_sel !== 3'd1 || ia.pixel_out !== 4'h6) ok = 1'b0;
      if (i == 5) ia.mem_ack = 1'b1;
    end
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL stall_hold got unstable request want addr=01a pix=1 data=6 for 6 cycles"); end
    @(negedge clk_25);
    n_vec++;
    if ((wr_a - w0) !== 1 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL stall_done got writes=%0d busy=%0b want 1 0", wr_a - w0, busy_a);
    end
  endtask

  task automatic test_blank();
    int w0;
    bit ok;
    w0 = wr_b; ok = 1'b1;
    ib.mem_ack = 1'b1;
    disp_active = 1'b1;
    issue(1'b1, 2'b01, 1'b1, 6'd7, 6'd0, 6'd2, 4'h5);
    repeat (10) begin
      @(negedge clk_25);
      if (ib.mem_req !== 1'b0 || busy_b !== 1'b1) ok = 1'b0;
    end
    n_vec++;
    if (!ok || (wr_b - w0) !== 0) begin
      n_bad++; $display("FAIL blank_wait got early request writes=%0d want 0", wr_b - w0);
    end
    disp_active = 1'b0;
    repeat (3) @(posedge clk_25);
    #1 disp_active = 1'b1;
    @(negedge clk_25);
    n_vec++;
    if (ib.mem_req !== 1'b0 || ib.addr !== 9'd16 || ib.pix_sel !== 3'd3 || (wr_b - w0) !== 3) begin
      n_bad++; $display("FAIL blank_drop got req=%0b addr=%0d pix=%0d writes=%0d want 0 16 3 3",
                        ib.mem_req, ib.addr, ib.pix_sel, wr_b - w0);
    end
    repeat (3) @(negedge clk_25);
    n_vec++;
    if (ib.pix_sel !== 3'd3 || (wr_b - w0) !== 3) begin
      n_bad++; $display("FAIL blank_hold got pix=%0d writes=%0d want 3 3", ib.pix_sel, wr_b - w0);
    end
    disp_active = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_25);
      if (!busy_b) break;
    end
    n_vec++;
    if ((wr_b - w0) !== 8 || busy_b !== 1'b0) begin
      n_bad++; $display("FAIL blank_total got writes=%0d busy=%0b want 8 0", wr_b - w0, busy_b);
    end
  endtask

  task automatic test_err();
    int r0, e0;
    for (int t = 0; t < 2; t++) begin
      r0 = req_a; e0 = errc_a;
      if (t == 0) issue(1'b0, 2'b00, 1'b0, 6'd5, 6'd5, 6'd48, 4'h1);
      else        issue(1'b0, 2'b11, 1'b0, 6'd1, 6'd2, 6'd0,  4'h1);
      @(negedge clk_25);
      n_vec++;
      if (err_a !== 1'b1 || ia.mem_req !== 1'b0 || ia.cmd_ready !== 1'b0) begin
        n_bad++; $display("FAIL err_pulse[%0d] got err=%0b req=%0b ready=%0b want 1 0 0",
                          t, err_a, ia.mem_req, ia.cmd_ready);
      end
      @(negedge clk_25);
      n_vec++;
      if (err_a !== 1'b0 || ia.cmd_ready !== 1'b1 || (req_a - r0) !== 0 || (errc_a - e0) !== 1) begin
        n_bad++; $display("FAIL err_end[%0d] got err=%0b ready=%0b reqs=%0d pulses=%0d want 0 1 0 1",
                          t, err_a, ia.cmd_ready, req_a - r0, errc_a - e0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_a;
    ia.mem_ack = 1'b1;
    issue(1'b0, 2'b10, 1'b1, 6'd0, 6'd0, 6'd0, 4'h9);
    repeat (100) @(posedge clk_25);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (ia.mem_req !== 1'b0 || busy_a !== 1'b0 || (wr_a - w0) !== 100) begin
      n_bad++; $display("FAIL rstmid_drop got req=%0b busy=%0b writes=%0d want 0 0 100",
                        ia.mem_req, busy_a, wr_a - w0);
    end
    @(negedge clk_25);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_25);
    n_vec++;
    if (ia.cmd_ready !== 1'b1 || busy_a !== 1'b0 || (wr_a - w0) !== 100) begin
      n_bad++; $display("FAIL rstmid_after got ready=%0b busy=%0b writes=%0d want 1 0 100",
                        ia.cmd_ready, busy_a, wr_a - w0);
    end
  endtask

  initial begin
    ia.cmd_valid = 1'b0; ia.cmd_op = 2'b00; ia.cmd_bank = 1'b0; ia.cmd_x0 = '0;
    ia.cmd_x1 = '0; ia.cmd_y = '0; ia.cmd_colour = '0; ia.mem_ack = 1'b0;
    ib.cmd_valid = 1'b0; ib.cmd_op = 2'b00; ib.cmd_bank = 1'b0; ib.cmd_x0 = '0;
    ib.cmd_x1 = '0; ib.cmd_y = '0; ib.cmd_colour = '0; ib.mem_ack = 1'b0;
    test_reset();
    test_plot();
    test_hline();
    test_fill();
    test_stall();
    test_blank();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
